// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux_pkg: shared constants and width helper for the rr_arb_mux block.
//   MODE_FIXED / MODE_RR : encodings of the Mode input.
//   clog2w(n)            : index width for n channels, never less than 1 bit.
package rr_arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: purely combinational round-robin search.
//   req   : request vector, one bit per channel
//   ptr   : last granted channel; search starts at (ptr+1) mod NUM_CH
//   grant : one-hot grant (all zero when no request)
//   idx   : binary index of the granted channel (0 when no request)
module rr_priority_picker
  import rr_arb_mux_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [clog2w(NUM_CH)-1:0] ptr,
  output logic [NUM_CH-1:0]         grant,
  output logic [clog2w(NUM_CH)-1:0] idx
);

  localparam int IW = clog2w(NUM_CH);

  always_comb begin
    logic found;
    int   c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    // k = NUM_CH wraps back to ptr itself, so it has the lowest priority.
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(ptr) + k) % NUM_CH;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-to-1 arbitrated mux with a one-entry registered output.
//   Clk, Reset          : clock, async active-high reset
//   In / InValid / InReady : packed per-channel data with valid/ready
//   Mode, Sel           : 0 = fixed channel Sel, 1 = round-robin
//   Out / OutValid / OutReady / OutCh : registered word, its handshake and
//                         source channel
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_CH*WIDTH-1:0]   In,
  input  logic [NUM_CH-1:0]         InValid,
  output logic [NUM_CH-1:0]         InReady,
  input  logic                      Mode,
  input  logic [clog2w(NUM_CH)-1:0] Sel,
  output logic [WIDTH-1:0]          Out,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [clog2w(NUM_CH)-1:0] OutCh
);

  localparam int IW = clog2w(NUM_CH);

  logic [IW-1:0]     ptr;
  logic [NUM_CH-1:0] rr_grant, fix_grant, grant;
  logic [IW-1:0]     rr_idx, gnt_idx;
  logic [WIDTH-1:0]  gnt_data;
  logic              load_en, xfer;

  rr_priority_picker #(.NUM_CH(NUM_CH)) u_picker (
    .req   (InValid),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // Fixed mode: an out-of-range Sel matches no channel and grants nothing.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      fix_grant[i] = (int'(Sel) == i) && InValid[i];
  end

  assign grant   = (Mode == MODE_RR) ? rr_grant : fix_grant;
  assign gnt_idx = (Mode == MODE_RR) ? rr_idx   : Sel;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (grant[i]) gnt_data = In[i*WIDTH +: WIDTH];
  end

  assign load_en = !OutValid || OutReady;
  // Reset gates the strobes so nothing is accepted while the register is held.
  assign InReady = (load_en && !Reset) ? grant : '0;
  assign xfer    = |InReady;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Out      <= '0;
      OutValid <= 1'b0;
      OutCh    <= '0;
      ptr      <= IW'(NUM_CH - 1);
    end else if (xfer) begin
      Out      <= gnt_data;
      OutCh    <= gnt_idx;
      OutValid <= 1'b1;
      ptr      <= gnt_idx;
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
module tb_rr_arb_mux;

  localparam int N = 4;
  localparam int W = 32;

  logic           Clk = 1'b0;
  logic           Reset;
  logic [N*W-1:0] In;
  logic [N-1:0]   InValid, InReady;
  logic           Mode, OutReady, OutValid;
  logic [1:0]     Sel, OutCh;
  logic [W-1:0]   Out;

  // Second instance for the non-power-of-two case.
  logic [3*W-1:0] In3;
  logic [2:0]     InValid3, InReady3;
  logic           Mode3, OutReady3, OutValid3;
  logic [1:0]     Sel3, OutCh3;
  logic [W-1:0]   Out3;

  always #5 Clk = ~Clk;

  rr_arb_mux #(.NUM_CH(N), .WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .In(In), .InValid(InValid), .InReady(InReady),
    .Mode(Mode), .Sel(Sel), .Out(Out), .OutValid(OutValid),
    .OutReady(OutReady), .OutCh(OutCh));

  rr_arb_mux #(.NUM_CH(3), .WIDTH(W)) dut3 (
    .Clk(Clk), .Reset(Reset), .In(In3), .InValid(InValid3), .InReady(InReady3),
    .Mode(Mode3), .Sel(Sel3), .Out(Out3), .OutValid(OutValid3),
    .OutReady(OutReady3), .OutCh(OutCh3));

  typedef struct { int ch; logic [W-1:0] d; } item_t;
  item_t        q[$];
  int           n_checks = 0, n_fail = 0;
  logic [W-1:0] words[N];
  int           m_ptr;
  bit           m_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: fixed picks Sel if valid; round-robin picks the
  // lowest valid channel above the pointer, else the lowest valid channel.
  function automatic int ref_grant(input bit md, input int sl, input logic [N-1:0] iv, input int p);
    if (!md) return (sl < N && iv[sl]) ? sl : -1;
    for (int c = p + 1; c < N; c++) if (iv[c]) return c;
    for (int c = 0; c <= p; c++) if (iv[c]) return c;
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ptr   = N - 1;
    m_valid = 0;
  endtask

  // One clock of stimulus; checks OutValid and InReady against the model and
  // pushes any expected output word to the scoreboard.
  task automatic cycle(input bit md, input int sl, input logic [N-1:0] iv, input bit ordy);
    int g;
    bit load_en;
    @(posedge Clk); #2;
    chk("out_valid", OutValid, m_valid);
    Mode = md; Sel = sl[1:0]; InValid = iv; OutReady = ordy;
    for (int i = 0; i < N; i++) In[i*W +: W] = words[i];
    #1;
    load_en = !m_valid || ordy;
    g = ref_grant(md, sl, iv, m_ptr);
    chk("in_ready", InReady, (g >= 0 && load_en) ? (64'd1 << g) : 64'd0);
    if (g >= 0 && load_en) begin
      q.push_back('{ch: g, d: words[g]});
      m_ptr   = g;
      m_valid = 1;
    end else if (ordy) begin
      m_valid = 0;
    end
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge Clk) begin
    if (!Reset && OutValid && OutReady) begin
      if (q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL spurious_out: got ch %0d data %0h expected none", OutCh, Out);
      end else begin
        item_t e;
        e = q.pop_front();
        chk("out_ch", OutCh, e.ch);
        chk("out_data", Out, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1; InValid = '0; In = '0; Mode = 0; Sel = 0; OutReady = 0;
    In3 = '0; InValid3 = '0; Mode3 = 0; Sel3 = 0; OutReady3 = 1;
    model_reset();
    #1;
    chk("rst_out_valid", OutValid, 0);
    chk("rst_out", Out, 0);
    chk("rst_out_ch", OutCh, 0);
    chk("rst_in_ready", InReady, 0);
    @(posedge Clk); @(posedge Clk); #2; Reset = 0;

    // Round-robin, all valid: 0,1,2,3,0 back to back.
    for (int i = 0; i < N; i++) words[i] = 32'hA0 + i;
    for (int k = 0; k < 5; k++) cycle(1, 0, 4'b1111, 1);

    // Fixed Sel=2.
    words[2] = 32'h1000_0000;
    cycle(0, 2, 4'b1111, 1);
    cycle(0, 2, 4'b0000, 1);

    // Stall 3 cycles after a load, then release.
    cycle(1, 0, 4'b1111, 0);
    for (int k = 0; k < 3; k++) cycle(1, 0, 4'b1111, 0);
    cycle(1, 0, 4'b1111, 1);
    cycle(1, 0, 4'b0000, 1);

    // Wrap-around skipping idle channels: set ptr to 1, then 3,1,3.
    cycle(0, 1, 4'b0010, 1);
    for (int k = 0; k < 3; k++) cycle(1, 0, 4'b1010, 1);

    // Reset mid-stall.
    cycle(1, 0, 4'b1111, 0);
    cycle(1, 0, 4'b1111, 0);
    Reset = 1;
    #1;
    chk("async_rst_valid", OutValid, 0);
    chk("async_rst_out", Out, 0);
    chk("async_rst_ready", InReady, 0);
    InValid = '0;
    model_reset();
    @(posedge Clk); #2; Reset = 0;
    cycle(1, 0, 4'b1111, 1);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) words[i] = $urandom;
      cycle($urandom_range(0, 1), $urandom_range(0, 3), 4'($urandom),
            $urandom_range(0, 9) < 7);
    end
    cycle(1, 0, 4'b0000, 1);
    cycle(1, 0, 4'b0000, 1);
    chk("sb_drained", q.size(), 0);

    // Three channels: Sel=3 is out of range and grants nothing.
    InValid = '0;
    In3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    InValid3 = 3'b111; Mode3 = 0; Sel3 = 2'd3;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); #3;
      chk("n3_in_ready", InReady3, 0);
      chk("n3_out_valid", OutValid3, 0);
    end
    Sel3 = 2'd2;
    #1;
    chk("n3_sel2_ready", InReady3, 3'b100);
    @(posedge Clk); #1;
    chk("n3_sel2_valid", OutValid3, 1);
    chk("n3_sel2_ch", OutCh3, 2);
    chk("n3_sel2_out", Out3, 32'h3333_3333);
    InValid3 = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
